// File: rtl/line_code_pkg.sv
// Shared line-code constants, FSM state type and legality helper
// used by the priority line encoder and the one-hot line driver.
package line_code_pkg;

    localparam int CODE_W = 7;
    localparam logic [CODE_W-1:0] CODE_NONE = 7'd127;
    localparam int NUM_LINES = 86;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } drv_state_t;

    // A code is legal when it names an existing select line (1..width-1)
    function automatic logic code_legal(
        input logic [CODE_W-1:0] code,
        input int                width
    );
        return (code != '0) && (int'(code) < width);
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Small synchronous FIFO holding pending line codes.
// DEPTH must be a power of two, at least 2.
module code_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/onehot_line_driver.sv
// Buffers line codes and drives one-hot select lines for HOLD cycles
// with a one-cycle gap. Macro ONEHOT_LINE_DRIVER_ERR_CNT_EN adds err_count.
module onehot_line_driver
    import line_code_pkg::*;
#(
    parameter int WIDTH = 87,
    parameter int HOLD  = 4,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic [WIDTH-2:0]  line_out,
    output logic              line_active,
    output logic              busy,
    output logic              err
`ifdef ONEHOT_LINE_DRIVER_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int LW = WIDTH - 1;
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    drv_state_t        state;
    drv_state_t        state_nx;
    logic              fire;
    logic              legal;
    logic              illegal;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CODE_W-1:0] head;
    logic [CW-1:0]     cnt;
    logic              load;
    logic              dec;
    logic              clr;

    assign code_ready  = !full;
    assign fire        = code_valid && code_ready;
    assign legal       = code_legal(code_in, WIDTH);
    assign illegal     = !legal && (code_in != CODE_NONE);
    assign push        = fire && legal;
    assign line_active = |line_out;
    assign busy        = (state != IDLE) || !empty;

    code_fifo #(
        .DEPTH (DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (code_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        load     = 1'b0;
        dec      = 1'b0;
        clr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    load     = 1'b1;
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    clr      = 1'b1;
                    state_nx = GAP;
                end else begin
                    dec = 1'b1;
                end
            end
            GAP: begin
                if (!empty) begin
                    pop      = 1'b1;
                    load     = 1'b1;
                    state_nx = DRIVE;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Only legal codes reach the FIFO, so head-1 always indexes a real line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_out <= '0;
            cnt      <= '0;
        end else if (load) begin
            line_out <= LW'(1) << (head - 1'b1);
            cnt      <= CW'(HOLD - 1);
        end else if (clr) begin
            line_out <= '0;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= fire && illegal;
    end

`ifdef ONEHOT_LINE_DRIVER_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (fire && illegal && (err_count != 8'hFF)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule
